multi_tank_hit_scorer: RTL

//  Parametrised hit detector and scoreboard for NUM_TANKS tanks, each with one bullet.

---
 rtl/multi_tank_hit_scorer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/multi_tank_hit_scorer.sv
// Bullet-vs-tank hit detector and scoreboard for NUM_TANKS tanks; auto-revive under RESPAWN_HIT_SCORER_EN.
// All outputs registered one clk_19 edge after sampled inputs; no backpressure, one evaluation per tick.
module multi_tank_hit_scorer #(
    parameter int NUM_TANKS     = 2,
    parameter int POS_W         = 10,
    parameter int TANK_SIZE     = 32,
    parameter int HIT_MARGIN    = 2,
    parameter int BUL_LONG      = 14,
    parameter int BUL_SHORT     = 7,
    parameter int SCORE_W       = 9,
    parameter int RESPAWN_TICKS = 64
) (
    input  logic                         clk_19,
    input  logic                         rst_n,
    input  logic                         restart_map,
    input  logic [NUM_TANKS*POS_W-1:0]   tank_ver,
    input  logic [NUM_TANKS*POS_W-1:0]   tank_hor,
    input  logic [NUM_TANKS-1:0]         bul_valid,
    input  logic [NUM_TANKS*2-1:0]       bul_dir,
    input  logic [NUM_TANKS*POS_W-1:0]   bul_ver,
    input  logic [NUM_TANKS*POS_W-1:0]   bul_hor,
    output logic [NUM_TANKS-1:0]         death,
    output logic [NUM_TANKS*SCORE_W-1:0] score,
    output logic [NUM_TANKS-1:0]         hit_pulse,
    output logic                         round_over,
    output logic                         draw
);

    localparam int PW = POS_W + 1;
    localparam int SW = SCORE_W + 2;
    localparam int AW = $clog2(NUM_TANKS + 1);

    localparam logic [PW-1:0] WIN_LO    = PW'(HIT_MARGIN);
    localparam logic [PW-1:0] WIN_HI    = PW'(TANK_SIZE - HIT_MARGIN);
    localparam logic [PW-1:0] LEN_LONG  = PW'(BUL_LONG);
    localparam logic [PW-1:0] LEN_SHORT = PW'(BUL_SHORT);
    localparam logic [SW-1:0] SCORE_MAX = {2'b00, {SCORE_W{1'b1}}};

    logic [PW-1:0] bul_top [NUM_TANKS];
    logic [PW-1:0] bul_bot [NUM_TANKS];
    logic [PW-1:0] bul_lft [NUM_TANKS];
    logic [PW-1:0] bul_rgt [NUM_TANKS];
    logic [PW-1:0] win_top [NUM_TANKS];
    logic [PW-1:0] win_bot [NUM_TANKS];
    logic [PW-1:0] win_lft [NUM_TANKS];
    logic [PW-1:0] win_rgt [NUM_TANKS];

    logic [NUM_TANKS-1:0]         hit [NUM_TANKS];
    logic [NUM_TANKS-1:0]         victim_hit;
    logic [NUM_TANKS-1:0]         shooter_hit;
    logic [SW-1:0]                credit [NUM_TANKS];
    logic [NUM_TANKS-1:0]         credited;
    logic [SW-1:0]                score_sum;
    logic [NUM_TANKS*SCORE_W-1:0] score_nxt;
    logic [NUM_TANKS-1:0]         revive;
    logic [NUM_TANKS-1:0]         death_nxt;
    logic [AW-1:0]                alive_cnt;

    // Box edges widened by one bit so that sums near the screen edge never wrap.
    always_comb begin
        for (int i = 0; i < NUM_TANKS; i++) begin
            bul_top[i] = {1'b0, bul_ver[i*POS_W +: POS_W]};
            bul_lft[i] = {1'b0, bul_hor[i*POS_W +: POS_W]};
            bul_bot[i] = {1'b0, bul_ver[i*POS_W +: POS_W]} + (bul_dir[2*i+1] ? LEN_SHORT : LEN_LONG);
            bul_rgt[i] = {1'b0, bul_hor[i*POS_W +: POS_W]} + (bul_dir[2*i+1] ? LEN_LONG : LEN_SHORT);
            win_top[i] = {1'b0, tank_ver[i*POS_W +: POS_W]} + WIN_LO;
            win_bot[i] = {1'b0, tank_ver[i*POS_W +: POS_W]} + WIN_HI;
            win_lft[i] = {1'b0, tank_hor[i*POS_W +: POS_W]} + WIN_LO;
            win_rgt[i] = {1'b0, tank_hor[i*POS_W +: POS_W]} + WIN_HI;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_TANKS; i++) begin
            hit[i] = '0;
            for (int j = 0; j < NUM_TANKS; j++) begin
                if (i != j) begin
                    hit[i][j] = bul_valid[i] & ~death[i] & ~death[j]
                              & (bul_top[i] < win_bot[j]) & (bul_bot[i] > win_top[j])
                              & (bul_lft[i] < win_rgt[j]) & (bul_rgt[i] > win_lft[j]);
                end
            end
        end
    end

    // Each victim credits only its lowest-index shooter.
    always_comb begin
        victim_hit  = '0;
        shooter_hit = '0;
        credited    = '0;
        for (int i = 0; i < NUM_TANKS; i++) begin
            credit[i]      = '0;
            shooter_hit[i] = |hit[i];
        end
        for (int j = 0; j < NUM_TANKS; j++) begin
            for (int i = 0; i < NUM_TANKS; i++) begin
                if (hit[i][j]) begin
                    victim_hit[j] = 1'b1;
                    if (!credited[j]) begin
                        credit[i]   = credit[i] + SW'(1);
                        credited[j] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        score_sum = '0;
        score_nxt = score;
        for (int i = 0; i < NUM_TANKS; i++) begin
            score_sum = {2'b00, score[i*SCORE_W +: SCORE_W]} + credit[i];
            if (score_sum > SCORE_MAX) begin
                score_nxt[i*SCORE_W +: SCORE_W] = SCORE_MAX[SCORE_W-1:0];
            end else begin
                score_nxt[i*SCORE_W +: SCORE_W] = score_sum[SCORE_W-1:0];
            end
        end
    end

`ifdef RESPAWN_HIT_SCORER_EN
    localparam int CW = $clog2(RESPAWN_TICKS + 1);

    logic [CW-1:0] rsp_cnt [NUM_TANKS];

    always_comb begin
        for (int j = 0; j < NUM_TANKS; j++) begin
            revive[j] = death[j] & (rsp_cnt[j] == CW'(1));
        end
    end

    // A dead tank cannot be hit, so loading and counting down never coincide.
    always_ff @(posedge clk_19) begin
        for (int j = 0; j < NUM_TANKS; j++) begin
            if (!rst_n || restart_map) begin
                rsp_cnt[j] <= '0;
            end else if (victim_hit[j]) begin
                rsp_cnt[j] <= CW'(RESPAWN_TICKS);
            end else if (death[j] && rsp_cnt[j] != '0) begin
                rsp_cnt[j] <= rsp_cnt[j] - CW'(1);
            end
        end
    end
`else
    assign revive = '0;
`endif

    assign death_nxt = (death | victim_hit) & ~revive;

    always_comb begin
        alive_cnt = '0;
        for (int j = 0; j < NUM_TANKS; j++) begin
            if (!death_nxt[j]) begin
                alive_cnt = alive_cnt + AW'(1);
            end
        end
    end

    always_ff @(posedge clk_19) begin
        if (!rst_n) begin
            death      <= '0;
            score      <= '0;
            hit_pulse  <= '0;
            round_over <= 1'b0;
            draw       <= 1'b0;
        end else if (restart_map) begin
            death      <= '0;
            hit_pulse  <= '0;
            round_over <= 1'b0;
            draw       <= 1'b0;
        end else begin
            death      <= death_nxt;
            score      <= score_nxt;
            hit_pulse  <= shooter_hit;
            round_over <= (alive_cnt <= AW'(1));
            draw       <= (alive_cnt == '0);
        end
    end

endmodule
